// File: rtl/rect_pkg.sv
// Shared constants for the RECTANGLE-80 round datapath:
// round count, S-box table and round-controller FSM encodings.
package rect_pkg;

  localparam int NR_DEF      = 25;
  localparam int ROUND_W_DEF = 5;

  // Entry n sits at SBOX[n]; entry 15 is the leftmost nibble.
  localparam logic [15:0][3:0] SBOX =
    64'h24F8_D30B_97E1_AC56;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WHITEN = 2'd2
  } rect_state_e;

  function automatic logic [3:0] sbox_f(
    input logic [3:0] n
  );
    return SBOX[n];
  endfunction

endpackage

// File: rtl/p_shift_state.sv
// RECTANGLE ShiftRow layer: row1 <<<1, row2 <<<12, row3 <<<13.
// Ports: iv_s0..3 in rows, ov_s0..3 rotated rows (combinational).
module p_shift_state (
  input  logic [15:0] iv_s0,
  input  logic [15:0] iv_s1,
  input  logic [15:0] iv_s2,
  input  logic [15:0] iv_s3,
  output logic [15:0] ov_s0,
  output logic [15:0] ov_s1,
  output logic [15:0] ov_s2,
  output logic [15:0] ov_s3
);

  assign ov_s0 = iv_s0;
  assign ov_s1 = {iv_s1[14:0], iv_s1[15]};
  assign ov_s2 = {iv_s2[3:0], iv_s2[15:4]};
  assign ov_s3 = {iv_s3[2:0], iv_s3[15:3]};

endmodule

// File: rtl/sub_column_state.sv
// RECTANGLE SubColumn layer: 16 parallel 4-bit S-boxes, one per column.
// Ports: iv_s0..3 in rows, ov_s0..3 substituted rows (combinational).
module sub_column_state
  import rect_pkg::*;
(
  input  logic [15:0] iv_s0,
  input  logic [15:0] iv_s1,
  input  logic [15:0] iv_s2,
  input  logic [15:0] iv_s3,
  output logic [15:0] ov_s0,
  output logic [15:0] ov_s1,
  output logic [15:0] ov_s2,
  output logic [15:0] ov_s3
);

  logic [3:0] col;
  logic [3:0] sub;

  always_comb begin
    ov_s0 = '0;
    ov_s1 = '0;
    ov_s2 = '0;
    ov_s3 = '0;
    col   = '0;
    sub   = '0;
    for (int j = 0; j < 16; j++) begin
      // Column nibble takes row0 as its LSB.
      col = {iv_s3[j], iv_s2[j], iv_s1[j], iv_s0[j]};
      sub = sbox_f(col);
      ov_s0[j] = sub[0];
      ov_s1[j] = sub[1];
      ov_s2[j] = sub[2];
      ov_s3[j] = sub[3];
    end
  end

endmodule

// File: rtl/rect_subcol_round_ctrl.sv
// RECTANGLE-80 round state register, key add + SubColumn, final whitening.
// Ports: i_clk/i_rst, i_start, iv_pt*, iv_rk*, ov_round_idx, ov_sc* (to
// ShiftRow), iv_ps* (from ShiftRow), o_busy, o_done, ov_ct*.
// Macro RECT_BACK_TO_BACK_EN: accept i_start in WHITEN and go straight to RUN.
module rect_subcol_round_ctrl
  import rect_pkg::*;
#(
  parameter int NR      = NR_DEF,
  parameter int ROUND_W = ROUND_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [15:0]        iv_pt0,
  input  logic [15:0]        iv_pt1,
  input  logic [15:0]        iv_pt2,
  input  logic [15:0]        iv_pt3,
  input  logic [15:0]        iv_rk0,
  input  logic [15:0]        iv_rk1,
  input  logic [15:0]        iv_rk2,
  input  logic [15:0]        iv_rk3,
  output logic [ROUND_W-1:0] ov_round_idx,
  output logic [15:0]        ov_sc0,
  output logic [15:0]        ov_sc1,
  output logic [15:0]        ov_sc2,
  output logic [15:0]        ov_sc3,
  input  logic [15:0]        iv_ps0,
  input  logic [15:0]        iv_ps1,
  input  logic [15:0]        iv_ps2,
  input  logic [15:0]        iv_ps3,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        ov_ct0,
  output logic [15:0]        ov_ct1,
  output logic [15:0]        ov_ct2,
  output logic [15:0]        ov_ct3
);

  rect_state_e st_q, st_d;
  logic [3:0][15:0] s_q, s_d;
  logic [3:0][15:0] ct_q, ct_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic done_q, done_d;

  logic [3:0][15:0] pt, rk, ps, x;

  assign pt = {iv_pt3, iv_pt2, iv_pt1, iv_pt0};
  assign rk = {iv_rk3, iv_rk2, iv_rk1, iv_rk0};
  assign ps = {iv_ps3, iv_ps2, iv_ps1, iv_ps0};
  assign x  = s_q ^ rk;

  sub_column_state u_sc (
    .iv_s0 (x[0]),
    .iv_s1 (x[1]),
    .iv_s2 (x[2]),
    .iv_s3 (x[3]),
    .ov_s0 (ov_sc0),
    .ov_s1 (ov_sc1),
    .ov_s2 (ov_sc2),
    .ov_s3 (ov_sc3)
  );

  always_comb begin
    st_d   = st_q;
    s_d    = s_q;
    ct_d   = ct_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (i_start) begin
          s_d   = pt;
          idx_d = '0;
          st_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d   = ps;
        idx_d = idx_q + ROUND_W'(1);
        if (idx_q == ROUND_W'(NR - 1)) begin
          st_d = ST_WHITEN;
        end
      end
      ST_WHITEN: begin
        ct_d   = x;
        done_d = 1'b1;
        idx_d  = '0;
        st_d   = ST_IDLE;
`ifdef RECT_BACK_TO_BACK_EN
        if (i_start) begin
          s_d  = pt;
          st_d = ST_RUN;
        end
`endif
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q   <= ST_IDLE;
      s_q    <= '0;
      ct_q   <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      s_q    <= s_d;
      ct_q   <= ct_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign ov_round_idx = idx_q;
  assign o_busy = (st_q == ST_RUN) || (st_q == ST_WHITEN);
  assign o_done = done_q;
  assign ov_ct0 = ct_q[0];
  assign ov_ct1 = ct_q[1];
  assign ov_ct2 = ct_q[2];
  assign ov_ct3 = ct_q[3];

endmodule

// File: tb/tb_rect_subcol_round_ctrl.sv
// Bench for rect_subcol_round_ctrl closed through p_shift_state.
// Scoreboard of expected ciphertexts, checked by a done-driven monitor.
module tb_rect_subcol_round_ctrl;

  localparam int NR = 25;
  localparam int RW = 5;
`ifdef RECT_BACK_TO_BACK_EN
  localparam int SP = NR + 1;
`else
  localparam int SP = NR + 2;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] pt0, pt1, pt2, pt3;
  logic [15:0] rk0, rk1, rk2, rk3;
  logic [15:0] sc0, sc1, sc2, sc3;
  logic [15:0] ps0, ps1, ps2, ps3;
  logic [15:0] ct0, ct1, ct2, ct3;
  logic [RW-1:0] idx;
  logic busy, done;
  bit keyed;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int done_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rkf(
    input bit kd, input int i, input int r
  );
    int v;
    if (!kd) return 16'h0;
    v = (i * 291) ^ (r * 7941) ^ 42435;
    return v[15:0];
  endfunction

  assign rk0 = rkf(keyed, int'(idx), 0);
  assign rk1 = rkf(keyed, int'(idx), 1);
  assign rk2 = rkf(keyed, int'(idx), 2);
  assign rk3 = rkf(keyed, int'(idx), 3);

  rect_subcol_round_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .iv_pt0       (pt0),
    .iv_pt1       (pt1),
    .iv_pt2       (pt2),
    .iv_pt3       (pt3),
    .iv_rk0       (rk0),
    .iv_rk1       (rk1),
    .iv_rk2       (rk2),
    .iv_rk3       (rk3),
    .ov_round_idx (idx),
    .ov_sc0       (sc0),
    .ov_sc1       (sc1),
    .ov_sc2       (sc2),
    .ov_sc3       (sc3),
    .iv_ps0       (ps0),
    .iv_ps1       (ps1),
    .iv_ps2       (ps2),
    .iv_ps3       (ps3),
    .o_busy       (busy),
    .o_done       (done),
    .ov_ct0       (ct0),
    .ov_ct1       (ct1),
    .ov_ct2       (ct2),
    .ov_ct3       (ct3)
  );

  p_shift_state u_ps (
    .iv_s0 (sc0),
    .iv_s1 (sc1),
    .iv_s2 (sc2),
    .iv_s3 (sc3),
    .ov_s0 (ps0),
    .ov_s1 (ps1),
    .ov_s2 (ps2),
    .ov_s3 (ps3)
  );

  function automatic logic [3:0] sb(input logic [3:0] n);
    case (n)
      4'h0: return 4'h6;  4'h1: return 4'h5;
      4'h2: return 4'hC;  4'h3: return 4'hA;
      4'h4: return 4'h1;  4'h5: return 4'hE;
      4'h6: return 4'h7;  4'h7: return 4'h9;
      4'h8: return 4'hB;  4'h9: return 4'h0;
      4'hA: return 4'h3;  4'hB: return 4'hD;
      4'hC: return 4'h8;  4'hD: return 4'hF;
      4'hE: return 4'h4;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [15:0] rotl(
    input logic [15:0] v, input int n
  );
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [63:0] model(
    input logic [63:0] p, input bit kd
  );
    logic [15:0] s [4];
    logic [15:0] y [4];
    logic [3:0] n, v;
    for (int r = 0; r < 4; r++) s[r] = p[16*r +: 16];
    for (int rd = 0; rd < NR; rd++) begin
      for (int r = 0; r < 4; r++) begin
        s[r] = s[r] ^ rkf(kd, rd, r);
        y[r] = 16'h0;
      end
      for (int j = 0; j < 16; j++) begin
        n = {s[3][j], s[2][j], s[1][j], s[0][j]};
        v = sb(n);
        for (int r = 0; r < 4; r++) y[r][j] = v[r];
      end
      s[0] = y[0];
      s[1] = rotl(y[1], 1);
      s[2] = rotl(y[2], 12);
      s[3] = rotl(y[3], 13);
    end
    return {s[3] ^ rkf(kd, NR, 3), s[2] ^ rkf(kd, NR, 2),
            s[1] ^ rkf(kd, NR, 1), s[0] ^ rkf(kd, NR, 0)};
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {ct3, ct2, ct1, ct0}, 64'h0);
        if ({ct3, ct2, ct1, ct0} == 64'h0) begin
          errors++;
          $display("FAIL unexpected_done: got done want none");
        end
      end else begin
        chk("ciphertext", {ct3, ct2, ct1, ct0}, exp_q.pop_front());
      end
    end
  end

  task automatic set_pt(input logic [63:0] p);
    {pt3, pt2, pt1, pt0} = p;
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ndone(input int target);
    int i;
    i = 0;
    while (done_cyc.size() < target && i < 300) begin
      @(negedge clk);
      i++;
    end
    #1;
    chk("done_timeout", 64'(done_cyc.size() >= target), 64'h1);
  endtask

  logic [63:0] last_exp;
  int n0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    keyed = 1'b0;
    set_pt(64'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_idx", 64'(idx), 64'h0);
    chk("rst_ct", {ct3, ct2, ct1, ct0}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    set_pt(64'h0000_0000_0000_0001);
    exp_q.push_back(model(64'h0000_0000_0000_0001, 1'b0));
    n0 = done_cyc.size();
    launch();
    chk("col_order_sc", {sc3, sc2, sc1, sc0},
        64'h0000_FFFF_FFFE_0001);
    wait_ndone(n0 + 1);
    @(negedge clk);

    set_pt(64'h0);
    exp_q.push_back(model(64'h0, 1'b0));
    launch();
    chk("zero_round0", {ps3, ps2, ps1, ps0},
        64'h0000_FFFF_FFFF_0000);
    for (int k = 1; k <= NR + 2; k++) begin
      chk($sformatf("idx_c%0d", k), 64'(idx),
          64'((k <= NR + 1) ? k - 1 : 0));
      chk($sformatf("busy_c%0d", k), 64'(busy),
          64'(k <= NR + 1));
      chk($sformatf("done_c%0d", k), 64'(done),
          64'(k == NR + 2));
      if (k < NR + 2) @(negedge clk);
    end
    @(negedge clk);

    keyed = 1'b1;
    set_pt(64'h0123_4567_89AB_CDEF);
    exp_q.push_back(model(64'h0123_4567_89AB_CDEF, 1'b1));
    launch();
    for (int k = 1; k <= NR + 2; k++) begin
      start = (k == 5 || k == 12);
      chk($sformatf("ign_done_c%0d", k), 64'(done),
          64'(k == NR + 2));
      if (k < NR + 2) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    set_pt(64'hDEAD_BEEF_CAFE_F00D);
    launch();
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_idx", 64'(idx), 64'h0);
    chk("arst_ct", {ct3, ct2, ct1, ct0}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("arst_idle", 64'(busy), 64'h0);

    exp_q.push_back(model(64'hDEAD_BEEF_CAFE_F00D, 1'b1));
    n0 = done_cyc.size();
    launch();
    wait_ndone(n0 + 1);
    @(negedge clk);

    set_pt(64'h8000_0F0F_3C3C_FFFF);
    last_exp = model(64'h8000_0F0F_3C3C_FFFF, 1'b1);
    repeat (3) exp_q.push_back(last_exp);
    n0 = done_cyc.size();
    start = 1'b1;
    repeat (2 * SP + 1) @(negedge clk);
    start = 1'b0;
    wait_ndone(n0 + 3);
    if (done_cyc.size() >= n0 + 3) begin
      chk("spacing_1", 64'(done_cyc[n0+1] - done_cyc[n0]),
          64'(SP));
      chk("spacing_2", 64'(done_cyc[n0+2] - done_cyc[n0+1]),
          64'(SP));
    end
    repeat (40) @(negedge clk);
    chk("ct_held", {ct3, ct2, ct1, ct0}, last_exp);
    chk("extra_dones", 64'(done_cyc.size()), 64'(n0 + 3));
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/rect_subcol_round_ctrl.md
Name: rect_subcol_round_ctrl

Overview:
- Round-iterated state register and SubColumn layer for the RECTANGLE-80 round-based encryption core.
- Holds the 64-bit cipher state as four 16-bit rows.
- Each round cycle it XORs in the round key and applies SubColumn. It drives the result into the downstream ShiftRow stage (p_shift_state) and registers that stage's output back as the next state.
- After the last round it applies the final key whitening and presents the ciphertext to the core top.

Parameters:
- NR, 25, number of full rounds before final whitening.
- ROUND_W, 5, width of the round index; must satisfy 2^ROUND_W > NR.

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle request to begin encrypting iv_pt*.
- iv_pt0..iv_pt3  input  16 each  plaintext rows 0..3, sampled on an accepted start.
- iv_rk0..iv_rk3  input  16 each  round key rows for the round in ov_round_idx, from the key schedule, same cycle.
- ov_round_idx  output  ROUND_W  current round index; the key schedule uses it to select K[idx].
- ov_sc0..ov_sc3  output  16 each  SubColumn result, combinational; drives p_shift_state inputs.
- iv_ps0..iv_ps3  input  16 each  p_shift_state outputs, fed back as the next state.
- o_busy  output  1  high while in RUN or WHITEN.
- o_done  output  1  one-cycle pulse; ciphertext is valid in that cycle and held afterwards.
- ov_ct0..ov_ct3  output  16 each  ciphertext rows, registered, held until the next done.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - FSM to IDLE
  - state rows, ov_ct*, ov_round_idx to 0
  - o_busy and o_done to 0
- FSM states: IDLE, RUN, WHITEN.
- IDLE:
  - i_start=1 loads state<=iv_pt*, round_idx<=0, and moves to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - x_r = state_r ^ iv_rk_r.
  - For column j (0..15), the nibble n = {x3[j],x2[j],x1[j],x0[j]}, with row0 as the LSB.
  - Each nibble maps through S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2, and ov_scr[j] = S(n)[r].
  - state <= iv_ps*, round_idx <= round_idx+1.
  - If round_idx==NR-1, move to WHITEN; round_idx becomes NR.
- WHITEN:
  - ov_ct_r <= state_r ^ iv_rk_r, using key K[NR].
  - o_done<=1 for exactly the following cycle.
  - round_idx<=0, move to IDLE.
- ov_sc* is driven from state and iv_rk in all states. It is only meaningful in RUN. No output is gated.
- Latency:
  - Start accepted at edge E0.
  - NR RUN cycles, then one WHITEN cycle.
  - o_done is high in cycle NR+2 after E0, i.e. 27 cycles for NR=25.
- i_start while o_busy=1 is ignored; the round in progress is unaffected. Exception: see the optional feature.
- i_start held high continuously restarts immediately after each done. IDLE occupies 1 cycle between jobs.
- ov_ct* retains its last value through subsequent jobs until the next WHITEN.
- Reset asserted mid-operation aborts the job. No done pulse is produced and ov_ct* is cleared.
- The round index never exceeds NR; no wrap-around.

Optional Feature:
- Macro: RECT_BACK_TO_BACK_EN.
- Defined:
  - i_start in the WHITEN cycle is accepted. The ciphertext is registered as normal and o_done still pulses.
  - In the same edge, state<=iv_pt*, round_idx<=0, and the FSM goes directly to RUN.
  - Throughput is one block per NR+1 cycles.
- Undefined: i_start in WHITEN is ignored, as in any busy state.

Decomposition:
- Shared package rect_pkg holds:
  - NR and ROUND_W defaults
  - the S-box constant array
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, WHITEN=2'd2)
- One sub-module is natural: sub_column_state, a pure combinational 16-column S-box layer on four 16-bit rows. It mirrors p_shift_state's port style.
- The bench instantiates this block with p_shift_state connected on the ov_sc*/iv_ps* loop.

Test Plan:
- Zero PT, all round keys 0, start: after the first RUN edge, state == {0000,FFFF,FFFF,0000}, rows 0..3. This follows from S(0)=6 and the row rotations of all-ones/all-zeros being unchanged.
- Zero PT, zero key schedule, full run: o_done in cycle 27 after start. ov_ct* matches the C golden model, and ov_round_idx sequence 0..25 then 0.
- Start pulsed at cycles 5 and 12 of a job: ignored. Ciphertext equals the single-job result, and exactly one done.
- i_rst at RUN cycle 10: outputs go 0 asynchronously and the FSM returns to IDLE. No done follows, and a fresh start gives the correct result.
- i_start held high over 3 blocks:
  - macro off: done spacing is 27 cycles.
  - RECT_BACK_TO_BACK_EN: done spacing is 26 cycles, and every ciphertext matches the model.
- Column ordering check: PT row0=0x0001, other rows 0, key 0. After round 0, column 0 nibble = S(1)=5 before shift: ov_sc0[0]=1, ov_sc1[0]=0, ov_sc2[0]=1, ov_sc3[0]=0.
